// File: rtl/ucsbece154_icache_refill.sv
// I-cache refill initiator: takes one miss, bursts a block-aligned line from instruction memory,
// forwards the critical word early, then hands the complete line back to the cache.
module ucsbece154_icache_refill #(
    parameter int BLOCK_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MissValid,
    input  logic [31:0]               MissAddress,
    output logic                      MissReady,
    output logic                      ReadRequest,
    output logic [31:0]               ReadAddress,
    input  logic [31:0]               DataIn,
    input  logic                      DataReady,
    output logic                      CritValid,
    output logic [31:0]               CritWord,
    output logic                      RefillValid,
    output logic [31:0]               RefillAddress,
    output logic [32*BLOCK_WORDS-1:0] RefillLine,
    output logic                      RefillError,
    output logic [2:0]                dbg_state_o
);

    localparam int IDXW = $clog2(BLOCK_WORDS);
    localparam int OFF  = IDXW + 2;
    localparam int TW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // Handshake: a miss transfers on a cycle with MissValid && MissReady; MissReady is high only in
    // S_IDLE, and any MissValid seen in another state is dropped, never queued.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [IDXW-1:0]          beat_q, beat_d;
    logic [IDXW-1:0]          crit_idx_q, crit_idx_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [31:0]              addr_q, addr_d;
    logic [32*BLOCK_WORDS-1:0] line_q, line_d;
    logic [31:0]              crit_word_q, crit_word_d;
    logic                     crit_valid_q, crit_valid_d;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^MissAddress[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            crit_idx_q   <= '0;
            tmo_q        <= '0;
            addr_q       <= '0;
            line_q       <= '0;
            crit_word_q  <= '0;
            crit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            crit_idx_q   <= crit_idx_d;
            tmo_q        <= tmo_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            crit_word_q  <= crit_word_d;
            crit_valid_q <= crit_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        crit_idx_d   = crit_idx_q;
        tmo_d        = tmo_q;
        addr_d       = addr_q;
        line_d       = line_q;
        crit_word_d  = crit_word_q;
        crit_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MissValid) begin
                    addr_d     = {MissAddress[31:OFF], {OFF{1'b0}}};
                    crit_idx_d = MissAddress[OFF-1:2];
                    beat_d     = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT, S_FILL: begin
                if (DataReady) begin
                    line_d[32*beat_q +: 32] = DataIn;
                    beat_d = beat_q + 1'b1;
                    tmo_d  = '0;
                    if (beat_q == crit_idx_q) begin
                        crit_word_d  = DataIn;
                        crit_valid_d = 1'b1;
                    end
                    state_d = (beat_q == IDXW'(BLOCK_WORDS - 1)) ? S_DONE : S_FILL;
                end else if (TIMEOUT_CYCLES != 0) begin
                    // Abort lands exactly TIMEOUT_CYCLES cycles after the last beat or WAIT entry.
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign MissReady     = (state_q == S_IDLE);
    assign ReadRequest   = (state_q == S_REQ);
    assign RefillValid   = (state_q == S_DONE);
    assign RefillError   = (state_q == S_ABORT);
    assign ReadAddress   = addr_q;
    assign RefillAddress = addr_q;
    assign RefillLine    = line_q;
    assign CritWord      = crit_word_q;
    assign CritValid     = crit_valid_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ucsbece154_icache_refill.sv
// Directed bench for the I-cache refill initiator: expectations go into queues at issue time and a
// negedge monitor pops and compares them whenever the DUT pulses an output.
module tb_ucsbece154_icache_refill;

    localparam int BW = 4;
    localparam int T0 = 40;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc = cyc + 32'd1;

    // main DUT (default timeout)
    logic          miss_valid = 1'b0;
    logic [31:0]   miss_addr = 32'd0;
    logic          miss_ready;
    logic          read_request;
    logic [31:0]   read_address;
    logic [31:0]   data_in = 32'd0;
    logic          data_ready = 1'b0;
    logic          crit_valid;
    logic [31:0]   crit_word;
    logic          refill_valid;
    logic [31:0]   refill_address;
    logic [127:0]  refill_line;
    logic          refill_error;
    logic [2:0]    dbg_state;

    // second DUT with a short timeout and a silent memory
    logic          to_miss_valid = 1'b0;
    logic [31:0]   to_miss_addr = 32'd0;
    logic          to_miss_ready;
    logic          to_read_request;
    logic [31:0]   to_read_address;
    logic [31:0]   to_data_in = 32'd0;
    logic          to_data_ready = 1'b0;
    logic          to_crit_valid;
    logic [31:0]   to_crit_word;
    logic          to_refill_valid;
    logic [31:0]   to_refill_address;
    logic [127:0]  to_refill_line;
    logic          to_refill_error;
    logic [2:0]    to_dbg_state;

    ucsbece154_icache_refill #(.BLOCK_WORDS(BW), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .MissValid(miss_valid), .MissAddress(miss_addr), .MissReady(miss_ready),
        .ReadRequest(read_request), .ReadAddress(read_address),
        .DataIn(data_in), .DataReady(data_ready),
        .CritValid(crit_valid), .CritWord(crit_word),
        .RefillValid(refill_valid), .RefillAddress(refill_address), .RefillLine(refill_line),
        .RefillError(refill_error), .dbg_state_o(dbg_state)
    );

    ucsbece154_icache_refill #(.BLOCK_WORDS(BW), .TIMEOUT_CYCLES(10)) dut_to (
        .clk(clk), .reset(reset),
        .MissValid(to_miss_valid), .MissAddress(to_miss_addr), .MissReady(to_miss_ready),
        .ReadRequest(to_read_request), .ReadAddress(to_read_address),
        .DataIn(to_data_in), .DataReady(to_data_ready),
        .CritValid(to_crit_valid), .CritWord(to_crit_word),
        .RefillValid(to_refill_valid), .RefillAddress(to_refill_address), .RefillLine(to_refill_line),
        .RefillError(to_refill_error), .dbg_state_o(to_dbg_state)
    );

    // block 0x00010000 is text[0..3], block 0x00020000 is text[4..7]
    logic [31:0] text [0:7] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00302023,
                                32'hFE000EE3, 32'h00100213, 32'h40418233, 32'h0000006F};
    logic [31:0] hw [0:3] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};

    logic [63:0]  req_q[$];
    logic [63:0]  crit_q[$];
    logic [191:0] rv_q[$];
    logic [31:0]  rdy_q[$];
    logic [31:0]  err_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic mem_auto = 1'b1;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected pulse at cycle %0d", name, cyc);
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a[31:4] == 28'h0001000) return text[{1'b0, a[3:2]}];
        if (a[31:4] == 28'h0002000) return text[{1'b1, a[3:2]}];
        return 32'hBAD0_0000 | a;
    endfunction

    function automatic int pending();
        return req_q.size() + crit_q.size() + rv_q.size() + rdy_q.size() + err_q.size();
    endfunction

    // burst memory: first beat T0+1 cycles after the ReadRequest cycle, then one beat per cycle
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (mem_auto && reset && read_request) begin
                a = read_address;
                @(posedge clk);
                repeat (T0) @(posedge clk);
                for (int i = 0; i < BW; i++) begin
                    #1 data_ready = 1'b1;
                    data_in = mem_read(a + 32'(4 * i));
                    @(posedge clk);
                end
                #1 data_ready = 1'b0;
            end
        end
    end

    // monitor
    always @(negedge clk) begin
        logic [63:0]  e;
        logic [191:0] l;
        logic [31:0]  c;
        if (reset) begin
            if (read_request) begin
                if (req_q.size() == 0) unexpected("read_request");
                else begin
                    e = req_q.pop_front();
                    check("read_request", {128'b0, cyc, read_address}, {128'b0, e});
                end
            end
            if (crit_valid) begin
                if (crit_q.size() == 0) unexpected("crit_valid");
                else begin
                    e = crit_q.pop_front();
                    check("crit_word", {128'b0, cyc, crit_word}, {128'b0, e});
                end
            end
            if (refill_valid) begin
                if (rv_q.size() == 0) unexpected("refill_valid");
                else begin
                    l = rv_q.pop_front();
                    check("refill_line", {cyc, refill_address, refill_line}, l);
                end
            end
            if (refill_error) unexpected("refill_error");
            if (rdy_q.size() != 0 && cyc >= rdy_q[0]) begin
                c = rdy_q.pop_front();
                check("miss_ready", {128'b0, cyc, 31'b0, miss_ready}, {128'b0, c, 32'd1});
            end
            if (to_refill_error) begin
                if (err_q.size() == 0) unexpected("to_refill_error");
                else begin
                    c = err_q.pop_front();
                    check("to_refill_error", {160'b0, cyc}, {160'b0, c});
                end
            end
            if (to_refill_valid) unexpected("to_refill_valid");
            if (to_crit_valid) unexpected("to_crit_valid");
        end
    end

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (pending() == 0) break;
            @(posedge clk);
        end
        check(name, {160'b0, 32'(pending())}, 192'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic start_cycle(output logic [31:0] t);
        @(posedge clk);
        #1 t = cyc;
    endtask

    task automatic drop_miss();
        @(posedge clk);
        #1 miss_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] t;
        logic [31:0] t2;
        logic [8:0]  mask;
        int          b;

        // reset state
        @(negedge clk);
        check("reset_pulses", {188'b0, read_request, crit_valid, refill_valid, refill_error}, 192'd0);
        check("reset_regs", {read_address, refill_address, crit_word, refill_line}, 192'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {188'b0, miss_ready, to_miss_ready, dbg_state[1:0]}, {188'b0, 4'b1100});

        // 1: miss in the middle of a block
        start_cycle(t);
        req_q.push_back({t + 32'd1, 32'h00010000});
        crit_q.push_back({t + 32'd44, text[1]});
        rv_q.push_back({t + 32'd46, 32'h00010000, text[3], text[2], text[1], text[0]});
        rdy_q.push_back(t + 32'd47);
        miss_valid = 1'b1;
        miss_addr  = 32'h00010004;
        drop_miss();
        drain("t1_drain", 120);

        // 2: critical word is the last beat
        start_cycle(t);
        req_q.push_back({t + 32'd1, 32'h00010000});
        crit_q.push_back({t + 32'd46, text[3]});
        rv_q.push_back({t + 32'd46, 32'h00010000, text[3], text[2], text[1], text[0]});
        rdy_q.push_back(t + 32'd47);
        miss_valid = 1'b1;
        miss_addr  = 32'h0001000C;
        drop_miss();
        drain("t2_drain", 120);

        // 3: hand-driven beats with gaps at +0,+2,+3,+7
        mem_auto = 1'b0;
        start_cycle(t);
        req_q.push_back({t + 32'd1, 32'h00010000});
        crit_q.push_back({t + 32'd7, hw[2]});
        rv_q.push_back({t + 32'd11, 32'h00010000, hw[3], hw[2], hw[1], hw[0]});
        rdy_q.push_back(t + 32'd12);
        miss_valid = 1'b1;
        miss_addr  = 32'h00010008;
        drop_miss();
        mask = 9'b100011010;
        b = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            if (mask[k]) begin
                data_ready = 1'b1;
                data_in    = hw[b];
                b++;
            end else begin
                data_ready = 1'b0;
                data_in    = 32'hFFFF_FFFF;
            end
        end
        @(posedge clk);
        #1 data_ready = 1'b0;
        drain("t3_drain", 40);

        // 4: silent memory on the short-timeout instance
        start_cycle(t);
        err_q.push_back(t + 32'd12);
        to_miss_valid = 1'b1;
        to_miss_addr  = 32'h00030004;
        @(posedge clk);
        #1 to_miss_valid = 1'b0;
        drain("t4_drain", 40);
        @(negedge clk);
        check("t4_idle", {188'b0, to_miss_ready, to_dbg_state}, {188'b0, 4'b1000});

        // 5: asynchronous reset after two beats
        start_cycle(t);
        req_q.push_back({t + 32'd1, 32'h00010000});
        crit_q.push_back({t + 32'd3, text[0]});
        miss_valid = 1'b1;
        miss_addr  = 32'h00010000;
        drop_miss();
        @(posedge clk);
        #1 data_ready = 1'b1;
        data_in = text[0];
        @(posedge clk);
        #1 data_in = text[1];
        @(posedge clk);
        #1 data_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t5_pulses", {188'b0, read_request, crit_valid, refill_valid, refill_error}, 192'd0);
        check("t5_regs", {read_address, refill_address, crit_word, refill_line}, 192'd0);
        check("t5_state", {189'b0, dbg_state}, 192'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        mem_auto = 1'b1;
        start_cycle(t);
        req_q.push_back({t + 32'd1, 32'h00010000});
        crit_q.push_back({t + 32'd45, text[2]});
        rv_q.push_back({t + 32'd46, 32'h00010000, text[3], text[2], text[1], text[0]});
        rdy_q.push_back(t + 32'd47);
        miss_valid = 1'b1;
        miss_addr  = 32'h00010008;
        drop_miss();
        drain("t5_drain", 120);

        // 6: MissValid held through the refill with a new address
        start_cycle(t);
        t2 = t + 32'd47;
        req_q.push_back({t + 32'd1, 32'h00010000});
        crit_q.push_back({t + 32'd44, text[1]});
        rv_q.push_back({t + 32'd46, 32'h00010000, text[3], text[2], text[1], text[0]});
        rdy_q.push_back(t2);
        req_q.push_back({t2 + 32'd1, 32'h00020000});
        crit_q.push_back({t2 + 32'd45, text[6]});
        rv_q.push_back({t2 + 32'd46, 32'h00020000, text[7], text[6], text[5], text[4]});
        rdy_q.push_back(t2 + 32'd47);
        miss_valid = 1'b1;
        miss_addr  = 32'h00010004;
        @(posedge clk);
        #1 miss_addr = 32'h00020008;
        repeat (47) @(posedge clk);
        #1 miss_valid = 1'b0;
        drain("t6_drain", 150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", pending());
        $fatal(1, "watchdog");
    end

endmodule
